// File: rtl/cfg_switch_box.sv
// Mux-based unidirectional switch box with a scan-loaded, double-buffered routing store.
// Define SB_REG_OUT_EN to register the out_* tracks (one extra cycle of latency).
module cfg_switch_box #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_n,
  input  logic [W-1:0] in_e,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_w,
  output logic [W-1:0] out_n,
  output logic [W-1:0] out_e,
  output logic [W-1:0] out_s,
  output logic [W-1:0] out_w,
  input  logic         cfg_in,
  input  logic         cfg_shift,
  input  logic         cfg_commit,
  output logic         cfg_out,
  output logic         cfg_ready,
  output logic         cfg_err
);
  localparam int CB = 8 * W;
  localparam int CW = $clog2(CB + 1);

  logic [CB-1:0]       shadow_q, shadow_d;
  logic [CB-1:0]       active_q, active_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [3:0][W-1:0]   in_arr;
  logic [3:0][W-1:0]   route;

  assign cfg_ready = (cnt_q == CW'(CB));
  assign cfg_out   = shadow_q[CB-1];
  assign cfg_err   = err_q;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (cfg_shift) begin
      shadow_d = {shadow_q[CB-2:0], cfg_in};
      if (!cfg_ready) cnt_d = cnt_q + 1'b1;
    end
    // Commit copies the pre-shift shadow; a concurrent shift counts as the first new bit.
    if (cfg_commit) begin
      if (cfg_ready) begin
        active_d = shadow_q;
        cnt_d    = cfg_shift ? CW'(1) : '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign in_arr = {in_w, in_s, in_e, in_n};

  genvar gd, gk;
  generate
    for (gd = 0; gd < 4; gd++) begin : g_side
      localparam int SIDE_CW  = (gd + 1) % 4;
      localparam int SIDE_ST  = (gd + 2) % 4;
      localparam int SIDE_CCW = (gd + 3) % 4;
      for (gk = 0; gk < W; gk++) begin : g_trk
        logic [1:0] sel;
        assign sel = active_q[2*(gd*W+gk) +: 2];
        // The ccw turn mirrors the track index across the side.
        assign route[gd][gk] = (sel == 2'b01) ? in_arr[SIDE_CW][gk] :
                               (sel == 2'b10) ? in_arr[SIDE_ST][gk] :
                               (sel == 2'b11) ? in_arr[SIDE_CCW][W-1-gk] : 1'b0;
      end
    end
  endgenerate

`ifdef SB_REG_OUT_EN
  logic [3:0][W-1:0] out_q;
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= route;
  end
  assign out_n = out_q[0];
  assign out_e = out_q[1];
  assign out_s = out_q[2];
  assign out_w = out_q[3];
`else
  assign out_n = route[0];
  assign out_e = route[1];
  assign out_s = route[2];
  assign out_w = route[3];
`endif

endmodule
